// File: rtl/efc_transition_sequencer.sv
// Initiator for the EFC place/transition network: picks one enabled, requested transition and fires it.
// Latency: req sampled at edge n, fire/tb_ok in cycle n+1, ack earliest in cycle n+2.
// Backpressure: one transition in flight; req is a level held until ack, disabled requests stay pending.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   req[6:0]          per-transition request, bit i = ti
//   p*_f1/p*_f2/p*_f3 place-marking outputs of FSM1/FSM2/FSM3
//   fire[6:0]         one-hot, one-cycle transition strobe (registered)
//   tb_ok[6:0]        barrier-satisfied strobe, identical timing to fire
//   ack[6:0]          one-cycle pulse when the post-fire marking is confirmed
//   busy, err         not-IDLE indicator; sticky marking-check failure
//   fire_count        confirmed firings, wraps
//   deadlock          no enabled transition for DEADLOCK_CYC idle cycles
// Optional feature macro: EFC_SEQ_DEADLOCK_DET_EN (undefined: deadlock tied 0).
module efc_transition_sequencer #(
  parameter int TIMEOUT      = 4,
  parameter int COUNT_W      = 16,
  parameter int DEADLOCK_CYC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         req,
  input  logic               p0_f1,
  input  logic               p2_f1,
  input  logic               p4_f1,
  input  logic               p6_f1,
  input  logic               p0_f2,
  input  logic               p7_f2,
  input  logic               p1_f3,
  input  logic               p2_f3,
  input  logic               p4_f3,
  input  logic               p6_f3,
  output logic [6:0]         fire,
  output logic [6:0]         tb_ok,
  output logic [6:0]         ack,
  output logic               busy,
  output logic               err,
  output logic [COUNT_W-1:0] fire_count,
  output logic               deadlock
);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, ERROR} state_t;
  // FSM2 places p3/p5 are not visible on the ports, so they are shadowed here.
  typedef enum logic [1:0] {BR_NONE, BR_P3, BR_P5} br_t;

  // Last timer value still tolerated in WAIT; TIMEOUT WAIT cycles in total.
  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_nxt;
  br_t        br;
  logic [6:0] en, cand, pick, g;
  logic       rr_pri;
  logic [3:0] timer;
  logic       match;

  // Enabling conditions from the current marking.
  always_comb begin
    en    = '0;
    en[0] = p0_f1 & p0_f2 & p1_f3;
    en[1] = p0_f1 & p0_f2 & p1_f3;
    en[2] = p2_f1 & p2_f3;
    en[3] = (br == BR_P3) & ~p0_f2 & ~p7_f2;
    en[4] = p4_f1 & p4_f3;
    en[5] = (br == BR_P5) & ~p0_f2 & ~p7_f2;
    en[6] = p6_f1 & p7_f2 & p6_f3;
  end

  assign cand = req & en;

  // t0/t1 is a free choice resolved round-robin; everything else goes lowest index first.
  always_comb begin
    pick = '0;
    if (cand[0] && cand[1]) pick = rr_pri ? 7'b0000010 : 7'b0000001;
    else                    pick = cand & (~cand + 7'd1);
  end

  // Expected marking after the granted transition has fired.
  assign match = (g[0] & p2_f1 & p2_f3 & ~p0_f2)
               | (g[1] & p4_f1 & p4_f3 & ~p0_f2)
               | ((g[2] | g[4]) & p6_f1 & p6_f3)
               | ((g[3] | g[5]) & p7_f2)
               | (g[6] & p0_f1 & p0_f2 & p1_f3);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|cand) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT: begin
        if (match)                    state_nxt = IDLE;
        else if (timer == TIMER_LAST) state_nxt = ERROR;
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; ack is a Mealy output so it can appear in the first WAIT cycle.
  always_comb begin
    ack  = '0;
    busy = (state != IDLE);
    err  = (state == ERROR);
    if (state == WAIT && match) ack = g;
  end

  // Grant, strobes, timer and bookkeeping. fire/tb_ok come straight from flops so
  // the async reset clears them without any decode glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g          <= '0;
      fire       <= '0;
      tb_ok      <= '0;
      timer      <= '0;
      rr_pri     <= 1'b0;
      br         <= BR_NONE;
      fire_count <= '0;
    end else begin
      fire  <= '0;
      tb_ok <= '0;
      case (state)
        IDLE: begin
          if (|cand) begin
            g     <= pick;
            fire  <= pick;
            tb_ok <= pick;
          end
        end
        FIRE: timer <= '0;
        WAIT: begin
          if (match) begin
            fire_count <= fire_count + COUNT_W'(1);
            if (g[0] | g[1]) rr_pri <= ~rr_pri;
            if (g[0])                br <= BR_P3;
            else if (g[1])           br <= BR_P5;
            else if (g[3] | g[5])    br <= BR_NONE;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EFC_SEQ_DEADLOCK_DET_EN
  localparam int DL_W = $clog2(DEADLOCK_CYC + 1);
  logic [DL_W-1:0] idle_cnt;

  // Counts consecutive IDLE cycles with nothing enabled; flag is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      deadlock <= 1'b0;
    end else if (state == IDLE && en == 7'd0) begin
      if (idle_cnt != DL_W'(DEADLOCK_CYC)) idle_cnt <= idle_cnt + DL_W'(1);
      if (idle_cnt == DL_W'(DEADLOCK_CYC - 1)) deadlock <= 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign deadlock = 1'b0;
`endif

endmodule

// File: tb/tb_efc_transition_sequencer.sv
module tb_efc_transition_sequencer;
  localparam int TIMEOUT = 4;
  localparam int COUNT_W = 16;
  localparam int DL      = 8;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] req;
  logic p0_f1, p2_f1, p4_f1, p6_f1, p0_f2, p7_f2, p1_f3, p2_f3, p4_f3, p6_f3;
  logic [6:0] fire, tb_ok, ack;
  logic busy, err, deadlock;
  logic [COUNT_W-1:0] fire_count;

  always #5 clk = ~clk;

  efc_transition_sequencer #(.TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W), .DEADLOCK_CYC(DL)) dut (
    .clk(clk), .reset(reset), .req(req),
    .p0_f1(p0_f1), .p2_f1(p2_f1), .p4_f1(p4_f1), .p6_f1(p6_f1),
    .p0_f2(p0_f2), .p7_f2(p7_f2),
    .p1_f3(p1_f3), .p2_f3(p2_f3), .p4_f3(p4_f3), .p6_f3(p6_f3),
    .fire(fire), .tb_ok(tb_ok), .ack(ack), .busy(busy), .err(err),
    .fire_count(fire_count), .deadlock(deadlock)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Petri-net view of the FSM bank: current place of each FSM, and each
  // transition's pre/post place per FSM (-1 = FSM not involved).
  int s1, s2, s3;
  int pre1[7] = '{0, 0, 2, -1, 4, -1, 6};
  int pre2[7] = '{0, 0, -1, 3, -1, 5, 7};
  int pre3[7] = '{1, 1, 2, -1, 4, -1, 6};
  int pst1[7] = '{2, 4, 6, -1, 6, -1, 0};
  int pst2[7] = '{3, 5, -1, 7, -1, 7, 0};
  int pst3[7] = '{2, 4, 6, -1, 6, -1, 1};

  function automatic bit enabled(int t);
    return (pre1[t] < 0 || pre1[t] == s1) && (pre2[t] < 0 || pre2[t] == s2) &&
           (pre3[t] < 0 || pre3[t] == s3);
  endfunction

  // Reference model of the sequencer: phase 0 idle, 1 firing, 2 awaiting marking, 3 error.
  int ph, k, wt, cyc, t_fire, t_err;
  logic [15:0] m_cnt;
  bit rr, frozen, zero, rnd, hold;
  logic [6:0] pend;
  int order[$];

  task automatic drive_places();
    p0_f1 = !zero && s1 == 0; p2_f1 = !zero && s1 == 2;
    p4_f1 = !zero && s1 == 4; p6_f1 = !zero && s1 == 6;
    p0_f2 = !zero && s2 == 0; p7_f2 = !zero && s2 == 7;
    p1_f3 = !zero && s3 == 1; p2_f3 = !zero && s3 == 2;
    p4_f3 = !zero && s3 == 4; p6_f3 = !zero && s3 == 6;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pend = '0; req = '0; s1 = 0; s2 = 0; s3 = 1;
    zero = 0; frozen = 0; hold = 0; rnd = 0;
    drive_places();
    ph = 0; rr = 0; m_cnt = '0; wt = 0; k = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  // One clock cycle: compare DUT against model at negedge, advance the model,
  // then apply requests and the bank's new marking just after the rising edge.
  task automatic cycle();
    logic [6:0] cand;
    logic [6:0] exp_fire;
    @(negedge clk);
    exp_fire = (ph == 1) ? (7'b1 << k) : 7'b0;
    check("fire", fire, exp_fire);
    check("tb_ok", tb_ok, exp_fire);
    check("ack", ack, (ph == 2 && !frozen) ? (7'b1 << k) : 7'b0);
    check("busy", busy, ph != 0);
    check("err", err, ph == 3);
    check("fire_count", fire_count, m_cnt);
    check("deadlock", deadlock, 0);
    for (int i = 0; i < 7; i++) if (ack[i] === 1'b1) order.push_back(i);
    if (fire != 0 && t_fire < 0) t_fire = cyc;
    if (err === 1'b1 && t_err < 0) t_err = cyc;
    cyc++;
    case (ph)
      0: begin
        cand = '0;
        for (int i = 0; i < 7; i++) if (pend[i] && enabled(i)) cand[i] = 1'b1;
        if (cand != 0) begin
          if (cand[0] && cand[1]) k = rr ? 1 : 0;
          else begin
            k = 0;
            while (!cand[k]) k++;
          end
          ph = 1;
        end
      end
      1: begin
        if (!frozen) begin
          if (pst1[k] >= 0) s1 = pst1[k];
          if (pst2[k] >= 0) s2 = pst2[k];
          if (pst3[k] >= 0) s3 = pst3[k];
        end
        ph = 2; wt = 0;
      end
      2: begin
        if (!frozen) begin
          m_cnt++;
          if (k < 2) rr = !rr;
          if (!hold) pend[k] = 1'b0;
          ph = 0;
        end else begin
          wt++;
          if (wt == TIMEOUT) ph = 3;
        end
      end
      default: ;
    endcase
    if (rnd) begin
      if ($urandom_range(0, 3) == 0) pend[$urandom_range(0, 6)] = 1'b1;
      if ($urandom_range(0, 15) == 0) pend[$urandom_range(0, 6)] = 1'b0;
    end
    @(posedge clk); #1;
    req = pend;
    drive_places();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int exp_order[8] = '{0, 2, 3, 6, 1, 4, 5, 6};

  initial begin
    cyc = 0; t_fire = -1; t_err = -1;
    reset = 1'b0; req = '0; pend = '0; s1 = 0; s2 = 0; s3 = 1;
    zero = 0; frozen = 0; hold = 0; rnd = 0;
    drive_places();
    @(negedge clk); @(negedge clk);
    check("rst_fire", fire, 0);
    check("rst_tb_ok", tb_ok, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_count", fire_count, 0);
    check("rst_deadlock", deadlock, 0);

    // Single t0 firing, then t3 which is only enabled if br moved to P3.
    do_reset();
    pend = 7'b0000001; req = pend;
    run(4);
    check("t0_count", fire_count, 1);
    pend = 7'b0001000; req = pend;
    run(4);
    check("t3_after_t0", fire_count, 2);

    // Full cycle t0, t2, t3, t6 requested together; disabled ones stay pending.
    do_reset();
    pend = 7'b1001101; req = pend;
    run(15);
    check("cycle_count", fire_count, 4);
    check("cycle_busy", busy, 0);

    // All requests held: two rounds, round robin swaps t0 for t1.
    do_reset();
    order.delete();
    hold = 1; pend = 7'h7F; req = pend;
    run(24);
    pend = '0; req = '0; hold = 0;
    run(2);
    check("rr_count", fire_count, 8);
    check("order_len", order.size(), 8);
    for (int i = 0; i < 8 && i < order.size(); i++) check("order", order[i], exp_order[i]);

    // Frozen bank: marking never moves, error after the timeout, then no grants.
    do_reset();
    frozen = 1; t_fire = -1; t_err = -1; cyc = 0;
    pend = 7'b0000001; req = pend;
    run(10);
    check("err_delay", t_err - t_fire, TIMEOUT + 1);
    pend = 7'h7F; req = pend;
    run(5);
    check("err_sticky", err, 1);

    // Reset asserted while the strobe is high.
    do_reset();
    pend = 7'b0000001; req = pend;
    run(1);
    @(negedge clk);
    check("fire_pre_rst", fire, 7'b0000001);
    reset = 1'b0;
    #1;
    check("fire_async_rst", fire, 0);
    check("busy_async_rst", busy, 0);
    do_reset();
    run(2);
    check("count_after_rst", fire_count, 0);

    // Randomised traffic against the model.
    do_reset();
    rnd = 1;
    run(1500);
    rnd = 0;
    check("rand_no_err", err, 0);

    // No marking at all: deadlock detection.
    do_reset();
    zero = 1;
    drive_places();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
`ifdef EFC_SEQ_DEADLOCK_DET_EN
      check("deadlock_flag", deadlock, i >= DL);
`else
      check("deadlock_flag", deadlock, 0);
`endif
      check("deadlock_busy", busy, 0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
